// File: rtl/wb_pkg.sv
// Shared writeback definitions: source indices, slot record, latency constant.
package wb_pkg;

  localparam int unsigned WB_XLEN = 32;
  localparam int unsigned WB_NSRC = 3;

  localparam int unsigned SRC_INT = 0;
  localparam int unsigned SRC_FP  = 1;
  localparam int unsigned SRC_AGU = 2;

  localparam int unsigned WB_LAT  = 2;

  typedef struct packed {
    logic               full;
    logic [4:0]         rd;
    logic               fp;
    logic [WB_XLEN-1:0] data;
  } wb_slot_t;

  // Bit XLEN of the register-file G bus marks the register as produced.
  function automatic logic [WB_XLEN:0] wb_pack(input logic [WB_XLEN-1:0] value);
    return {1'b1, value};
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-source / register-file-write bundle for wb_arbiter.
// Optional bypass signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSRC = 3
);
  logic [NSRC-1:0]      res_valid;
  logic [NSRC-1:0]      res_ready;
  logic [NSRC*5-1:0]    res_rd;
  logic [NSRC-1:0]      res_fp;
  logic [NSRC*XLEN-1:0] res_data;
  logic                 rd_we;
  logic                 frd_we;
  logic [4:0]           wb_rd;
  logic [XLEN:0]        wb_data;
  logic [1:0]           wb_src;
`ifdef WB_BYPASS_EN
  logic                 bypass_valid;
  logic [4:0]           bypass_rd;
  logic                 bypass_fp;
  logic [XLEN-1:0]      bypass_data;

  modport master (
    output res_valid, res_rd, res_fp, res_data,
    input  res_ready, rd_we, frd_we, wb_rd, wb_data, wb_src,
    input  bypass_valid, bypass_rd, bypass_fp, bypass_data
  );

  modport slave (
    input  res_valid, res_rd, res_fp, res_data,
    output res_ready, rd_we, frd_we, wb_rd, wb_data, wb_src,
    output bypass_valid, bypass_rd, bypass_fp, bypass_data
  );
`else
  modport master (
    output res_valid, res_rd, res_fp, res_data,
    input  res_ready, rd_we, frd_we, wb_rd, wb_data, wb_src
  );

  modport slave (
    input  res_valid, res_rd, res_fp, res_data,
    output res_ready, rd_we, frd_we, wb_rd, wb_data, wb_src
  );
`endif
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant plus index, search starts after the
// registered last-grant pointer, which resets to N-1 so request 0 wins first.
module rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(r_last) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= IW'(N - 1);
    end else if (i_advance && o_valid) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry slot per functional unit, round-robin drain
// into the integer or FP register-file write port. Option: WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = WB_XLEN,
  parameter int unsigned NSRC = WB_NSRC
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  wb_slot_t      r_slot [NSRC];
  logic          r_rd_we;
  logic          r_frd_we;
  logic [4:0]    r_wb_rd;
  logic [XLEN:0] r_wb_data;
  logic [1:0]    r_wb_src;

  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_grant;
  logic [NSRC-1:0] w_ready;
  logic [IW-1:0]   w_idx;
  logic            w_gvalid;
  wb_slot_t        w_gslot;
  logic            w_int_we;
  logic            w_fp_we;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_req[i] = r_slot[i].full;
    end
  end

  rr_arbiter #(.N(NSRC)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req),
    .i_advance (w_gvalid),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_valid   (w_gvalid)
  );

  // A draining slot accepts in the same cycle; no dependence on res_valid.
  assign w_ready       = ~w_req | w_grant;
  assign bus.res_ready = w_ready;

  // An x0 integer write still consumes the grant but never raises rd_we.
  always_comb begin
    w_gslot  = r_slot[w_idx];
    w_int_we = w_gvalid & ~w_gslot.fp & (w_gslot.rd != '0);
    w_fp_we  = w_gvalid & w_gslot.fp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        r_slot[i] <= '0;
      end
      r_rd_we   <= 1'b0;
      r_frd_we  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_src  <= '0;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (bus.res_valid[i] && w_ready[i]) begin
          r_slot[i].full <= 1'b1;
          r_slot[i].rd   <= bus.res_rd[5*i +: 5];
          r_slot[i].fp   <= bus.res_fp[i];
          r_slot[i].data <= bus.res_data[XLEN*i +: XLEN];
        end else if (w_grant[i]) begin
          r_slot[i].full <= 1'b0;
        end
      end
      r_rd_we  <= w_int_we;
      r_frd_we <= w_fp_we;
      if (w_int_we || w_fp_we) begin
        r_wb_rd   <= w_gslot.rd;
        r_wb_data <= wb_pack(w_gslot.data);
        r_wb_src  <= 2'(w_idx);
      end
    end
  end

  assign bus.rd_we   = r_rd_we;
  assign bus.frd_we  = r_frd_we;
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;
  assign bus.wb_src  = r_wb_src;

`ifdef WB_BYPASS_EN
  assign bus.bypass_valid = w_int_we | w_fp_we;
  assign bus.bypass_rd    = w_gslot.rd;
  assign bus.bypass_fp    = w_gslot.fp;
  assign bus.bypass_data  = w_gslot.data;
`endif

endmodule
